// File: rtl/slave_read.sv
// ---------------------------------------------------------------------------
// slave_read -- AXI read-channel slave in front of a single-port word memory.
//
// Accepts one AR request at a time, then walks the burst one beat at a time:
// FETCH strobes the memory, LOAD captures the returned word one cycle later,
// RESP presents the beat until the master accepts it. Every beat is 4 bytes
// and the burst type is always INCR.
//
// Optional feature (macro SLAVE_READ_RANGE_CHECK_EN): a request whose start
// address lies outside [ADDR_BASE, ADDR_BASE+ADDR_SIZE) is answered with an
// error burst (RRESP=2'b11, RDATA=0, no memory access) of the requested length.
//
// Ports
//   clk, rst            : clock (rising edge), synchronous active-high reset
//   AR*_S               : read address channel (ARSIZE_S/ARBURST_S ignored)
//   R*_S                : read data channel; data/resp/id/last are 0 when
//                         RVALID_S is low
//   mem_en, mem_addr    : memory read strobe and word address
//   mem_rdata           : memory data, valid the cycle after mem_en
// ---------------------------------------------------------------------------
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif

module slave_read #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter logic [31:0] ADDR_SIZE = 32'h0001_0000,
    parameter int unsigned MEM_AW    = 14
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [`AXI_ID_BITS-1:0]     ARID_S,
    input  logic [`AXI_ADDR_BITS-1:0]   ARADDR_S,
    input  logic [`AXI_LEN_BITS-1:0]    ARLEN_S,
    input  logic [`AXI_SIZE_BITS-1:0]   ARSIZE_S,
    input  logic [1:0]                  ARBURST_S,
    input  logic                        ARVALID_S,
    output logic                        ARREADY_S,
    output logic [`AXI_ID_BITS-1:0]     RID_S,
    output logic [`AXI_DATA_BITS-1:0]   RDATA_S,
    output logic [1:0]                  RRESP_S,
    output logic                        RLAST_S,
    output logic                        RVALID_S,
    input  logic                        RREADY_S,
    output logic                        mem_en,
    output logic [MEM_AW-1:0]           mem_addr,
    input  logic [31:0]                 mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        LOAD  = 2'b10,
        RESP  = 2'b11
    } state_t;

    state_t                      state_q, state_d;
    logic [`AXI_ID_BITS-1:0]     id_q, id_d;
    logic [`AXI_ADDR_BITS-1:0]   addr_q, addr_d;
    logic [`AXI_LEN_BITS-1:0]    len_q, len_d;
    logic [`AXI_LEN_BITS-1:0]    beat_q, beat_d;
    logic                        err_q, err_d;
    logic                        arready_q, arready_d;
    logic                        rvalid_q, rvalid_d;
    logic                        rlast_q, rlast_d;
    logic [`AXI_DATA_BITS-1:0]   rdata_q, rdata_d;
    logic [1:0]                  rresp_q, rresp_d;
    logic [`AXI_ID_BITS-1:0]     rid_q, rid_d;
    logic                        mem_en_q, mem_en_d;
    logic [MEM_AW-1:0]           mem_addr_q, mem_addr_d;

    logic                        range_err_s;
    logic [`AXI_ADDR_BITS-1:0]   addr_inc_s;
    logic [`AXI_LEN_BITS-1:0]    beat_inc_s;
    logic                        unused_s;

`ifdef SLAVE_READ_RANGE_CHECK_EN
    // Window end is computed one bit wider so a window touching 2^32 works.
    logic [32:0] win_end_s;
    assign win_end_s   = {1'b0, ADDR_BASE} + {1'b0, ADDR_SIZE};
    assign range_err_s = (ARADDR_S < ADDR_BASE) || ({1'b0, ARADDR_S} >= win_end_s);
    assign unused_s    = ^{ARSIZE_S, ARBURST_S};
`else
    assign range_err_s = 1'b0;
    assign unused_s    = ^{ARSIZE_S, ARBURST_S, ADDR_BASE, ADDR_SIZE};
`endif

    assign addr_inc_s = addr_q + 32'd4;
    assign beat_inc_s = beat_q + `AXI_LEN_BITS'(1);

    // Next-state and next-output logic for the burst sequencer.
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        addr_d     = addr_q;
        len_d      = len_q;
        beat_d     = beat_q;
        err_d      = err_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rlast_d    = rlast_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rid_d      = rid_q;
        mem_en_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        case (state_q)
            IDLE: begin
                arready_d = 1'b1;
                rvalid_d  = 1'b0;
                rlast_d   = 1'b0;
                rdata_d   = {`AXI_DATA_BITS{1'b0}};
                rresp_d   = 2'b00;
                rid_d     = {`AXI_ID_BITS{1'b0}};
                if (ARVALID_S && arready_q) begin
                    id_d      = ARID_S;
                    addr_d    = ARADDR_S;
                    len_d     = ARLEN_S;
                    beat_d    = {`AXI_LEN_BITS{1'b0}};
                    err_d     = range_err_s;
                    arready_d = 1'b0;
                    if (range_err_s) begin
                        // Error bursts skip the memory and answer immediately.
                        state_d  = RESP;
                        rvalid_d = 1'b1;
                        rresp_d  = 2'b11;
                        rid_d    = ARID_S;
                        rlast_d  = (ARLEN_S == {`AXI_LEN_BITS{1'b0}});
                    end else begin
                        state_d    = FETCH;
                        mem_en_d   = 1'b1;
                        mem_addr_d = ARADDR_S[MEM_AW+1:2];
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                state_d  = RESP;
                rvalid_d = 1'b1;
                rdata_d  = mem_rdata;
                rresp_d  = 2'b00;
                rid_d    = id_q;
                rlast_d  = (beat_q == len_q);
            end
            RESP: begin
                if (RREADY_S) begin
                    if (rlast_q) begin
                        state_d   = IDLE;
                        arready_d = 1'b1;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        rdata_d   = {`AXI_DATA_BITS{1'b0}};
                        rresp_d   = 2'b00;
                        rid_d     = {`AXI_ID_BITS{1'b0}};
                    end else begin
                        addr_d = addr_inc_s;
                        beat_d = beat_inc_s;
                        if (err_q) begin
                            state_d = RESP;
                            rdata_d = {`AXI_DATA_BITS{1'b0}};
                            rresp_d = 2'b11;
                            rlast_d = (beat_inc_s == len_q);
                        end else begin
                            state_d    = FETCH;
                            mem_en_d   = 1'b1;
                            mem_addr_d = addr_inc_s[MEM_AW+1:2];
                            rvalid_d   = 1'b0;
                            rlast_d    = 1'b0;
                            rdata_d    = {`AXI_DATA_BITS{1'b0}};
                            rresp_d    = 2'b00;
                            rid_d      = {`AXI_ID_BITS{1'b0}};
                        end
                    end
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d   = IDLE;
                arready_d = 1'b0;
                rvalid_d  = 1'b0;
                rlast_d   = 1'b0;
                rdata_d   = {`AXI_DATA_BITS{1'b0}};
                rresp_d   = 2'b00;
                rid_d     = {`AXI_ID_BITS{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            id_q       <= {`AXI_ID_BITS{1'b0}};
            addr_q     <= {`AXI_ADDR_BITS{1'b0}};
            len_q      <= {`AXI_LEN_BITS{1'b0}};
            beat_q     <= {`AXI_LEN_BITS{1'b0}};
            err_q      <= 1'b0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rdata_q    <= {`AXI_DATA_BITS{1'b0}};
            rresp_q    <= 2'b00;
            rid_q      <= {`AXI_ID_BITS{1'b0}};
            mem_en_q   <= 1'b0;
            mem_addr_q <= {MEM_AW{1'b0}};
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            err_q      <= err_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rlast_q    <= rlast_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rid_q      <= rid_d;
            mem_en_q   <= mem_en_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign ARREADY_S = arready_q;
    assign RVALID_S  = rvalid_q;
    assign RLAST_S   = rlast_q;
    assign RDATA_S   = rdata_q;
    assign RRESP_S   = rresp_q;
    assign RID_S     = rid_q;
    assign mem_en    = mem_en_q;
    assign mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_slave_read.sv
// Testbench for slave_read: directed scenarios plus randomized bursts, all
// checked every cycle against a transaction-level model of the slave.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif

module tb_slave_read;
    localparam int          MEM_AW = 14;
    localparam logic [31:0] BASE   = 32'h0000_0000;
    localparam logic [31:0] SIZE   = 32'h0001_0000;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic [`AXI_ID_BITS-1:0]    ARID_S = '0;
    logic [`AXI_ADDR_BITS-1:0]  ARADDR_S = '0;
    logic [`AXI_LEN_BITS-1:0]   ARLEN_S = '0;
    logic [`AXI_SIZE_BITS-1:0]  ARSIZE_S = 3'd2;
    logic [1:0]                 ARBURST_S = 2'b01;
    logic                       ARVALID_S = 1'b0;
    logic                       ARREADY_S;
    logic [`AXI_ID_BITS-1:0]    RID_S;
    logic [`AXI_DATA_BITS-1:0]  RDATA_S;
    logic [1:0]                 RRESP_S;
    logic                       RLAST_S;
    logic                       RVALID_S;
    logic                       RREADY_S = 1'b0;
    logic                       mem_en;
    logic [MEM_AW-1:0]          mem_addr;
    logic [31:0]                mem_rdata = 32'd0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    slave_read dut (
        .clk(clk), .rst(rst),
        .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S),
        .ARSIZE_S(ARSIZE_S), .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S),
        .ARREADY_S(ARREADY_S), .RID_S(RID_S), .RDATA_S(RDATA_S),
        .RRESP_S(RRESP_S), .RLAST_S(RLAST_S), .RVALID_S(RVALID_S),
        .RREADY_S(RREADY_S), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Cycle number of the most recent rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents as a pure function of the word address.
    function automatic logic [31:0] mem_f(input logic [MEM_AW-1:0] w);
        if (w == 14'd4) return 32'hDEAD_BEEF;
        return ({18'd0, w} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory: data one cycle after the strobe, garbage otherwise.
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem_f(mem_addr);
        else        mem_rdata <= $urandom;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic bit out_of_window(input logic [31:0] a);
`ifdef SLAVE_READ_RANGE_CHECK_EN
        longint la = longint'(a);
        return !(la >= longint'(BASE) && la < longint'(BASE) + longint'(SIZE));
`else
        return 1'b0;
`endif
    endfunction

    // Transaction-level model: current burst and the cycles at which things
    // become visible (all in units of rising-edge count).
    bit          m_busy = 1'b0;
    bit          m_err = 1'b0;
    logic [3:0]  m_id = '0;
    logic [31:0] m_base = '0;
    int          m_len = 0;
    int          m_beat = 0;
    int          m_valid_at = 0;
    int          m_idle_at = 1 << 30;
    int          m_rst_edge = -1;

    // Compare DUT against the model, then predict the effect of the next edge.
    always @(negedge clk) begin
        logic        ev, ea, emen;
        logic [31:0] eaddr;
        logic [13:0] eword;
        ev    = m_busy && (cyc >= m_valid_at);
        ea    = !m_busy && (cyc >= m_idle_at);
        eaddr = m_base + 32'(m_beat * 4);
        eword = eaddr[15:2];
        emen  = m_busy && !m_err && (cyc == m_valid_at - 2);
        chk("arready", ARREADY_S, ea);
        chk("rvalid", RVALID_S, ev);
        chk("rdata", RDATA_S, (ev && !m_err) ? mem_f(eword) : 32'd0);
        chk("rresp", RRESP_S, (ev && m_err) ? 2'b11 : 2'b00);
        chk("rid", RID_S, ev ? m_id : 4'd0);
        chk("rlast", RLAST_S, ev && (m_beat == m_len));
        chk("mem_en", mem_en, emen);
        if (emen) chk("mem_addr", mem_addr, eword);
        if (cyc == m_rst_edge) chk("mem_addr_rst", mem_addr, 14'd0);
        if (rst) begin
            m_busy     = 1'b0;
            m_idle_at  = cyc + 2;
            m_rst_edge = cyc + 1;
        end else begin
            if (ev && RREADY_S) begin
                if (m_beat == m_len) begin
                    m_busy    = 1'b0;
                    m_idle_at = cyc + 1;
                end else begin
                    m_beat++;
                    m_valid_at = m_err ? cyc + 1 : cyc + 3;
                end
            end
            if (ea && ARVALID_S) begin
                m_busy     = 1'b1;
                m_id       = ARID_S;
                m_base     = ARADDR_S;
                m_len      = int'(ARLEN_S);
                m_beat     = 0;
                m_err      = out_of_window(ARADDR_S);
                m_valid_at = m_err ? cyc + 1 : cyc + 3;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an AR request and hold it until accepted (bounded wait).
    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
        int n = 0;
        step();
        ARID_S = id; ARADDR_S = addr; ARLEN_S = len; ARVALID_S = 1'b1;
        @(negedge clk);
        while (!ARREADY_S && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!ARREADY_S) chk("ar_accept_timeout", 1'b0, 1'b1);
        step();
        ARVALID_S = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (m_busy && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (m_busy) chk("burst_end_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_rvalid();
        int n = 0;
        @(negedge clk);
        while (!RVALID_S && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!RVALID_S) chk("rvalid_timeout", 1'b0, 1'b1);
    endtask

    bit rnd_done = 1'b0;

    initial begin
        logic [13:0] seen [$];
        int          men_cnt, beats;
        logic [1:0]  resp0;
        logic [31:0] data0;
        bit          got0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", ARREADY_S, 1'b0);
        chk("rst_rvalid", RVALID_S, 1'b0);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_rdata", RDATA_S, 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("arready_first_cycle", ARREADY_S, 1'b0);
        @(negedge clk);
        chk("arready_after_rst", ARREADY_S, 1'b1);

        // Single beat from word 4.
        RREADY_S = 1'b1;
        send_ar(4'd3, 32'h10, 4'd0);
        @(negedge clk);
        chk("d1_mem_en", mem_en, 1'b1);
        chk("d1_mem_addr", mem_addr, 14'd4);
        @(negedge clk);
        chk("d1_rvalid_early", RVALID_S, 1'b0);
        @(negedge clk);
        chk("d1_rvalid", RVALID_S, 1'b1);
        chk("d1_rdata", RDATA_S, 32'hDEAD_BEEF);
        chk("d1_rlast", RLAST_S, 1'b1);
        chk("d1_rid", RID_S, 4'd3);
        chk("d1_rresp", RRESP_S, 2'b00);
        wait_idle();

        // Four-beat burst from 0x100.
        send_ar(4'hA, 32'h100, 4'd3);
        seen.delete();
        repeat (20) begin
            @(negedge clk);
            if (mem_en) seen.push_back(mem_addr);
        end
        chk("d2_fetches", 64'(seen.size()), 64'd4);
        for (int i = 0; i < 4 && i < seen.size(); i++)
            chk("d2_word", seen[i], 14'h40 + 14'(i));
        wait_idle();

        // Back-pressure: RREADY low for 5 cycles after RVALID.
        step();
        RREADY_S = 1'b0;
        send_ar(4'd7, 32'h44, 4'd0);
        wait_rvalid();
        repeat (5) begin
            step();
            @(negedge clk);
            chk("d3_hold_rvalid", RVALID_S, 1'b1);
            chk("d3_hold_rdata", RDATA_S, mem_f(14'h11));
        end
        step();
        RREADY_S = 1'b1;
        wait_idle();

        // Reset during beat 2 of a 4-beat burst.
        step();
        RREADY_S = 1'b0;
        send_ar(4'd5, 32'h40, 4'd3);
        wait_rvalid();
        step();
        RREADY_S = 1'b1;
        step();
        RREADY_S = 1'b0;
        wait_rvalid();
        step();
        rst = 1'b1;
        RREADY_S = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("d4_rvalid", RVALID_S, 1'b0);
        chk("d4_rid", RID_S, 4'd0);
        chk("d4_mem_addr", mem_addr, 14'd0);
        step();
        rst = 1'b0;
        send_ar(4'd9, 32'h20, 4'd0);
        wait_rvalid();
        chk("d4_new_rdata", RDATA_S, mem_f(14'd8));
        chk("d4_new_rid", RID_S, 4'd9);
        wait_idle();

        // Request just above the default window.
        send_ar(4'd6, 32'h0002_0000, 4'd1);
        men_cnt = 0; beats = 0; got0 = 1'b0; resp0 = 2'b00; data0 = 32'd0;
        repeat (12) begin
            @(negedge clk);
            if (mem_en) men_cnt++;
            if (RVALID_S && !got0) begin
                got0 = 1'b1; resp0 = RRESP_S; data0 = RDATA_S;
            end
            if (RVALID_S && RREADY_S) beats++;
        end
        chk("d5_beats", 64'(beats), 64'd2);
`ifdef SLAVE_READ_RANGE_CHECK_EN
        chk("d5_rresp", resp0, 2'b11);
        chk("d5_rdata", data0, 32'd0);
        chk("d5_mem_en_count", 64'(men_cnt), 64'd0);
`else
        chk("d5_rresp", resp0, 2'b00);
        chk("d5_rdata", data0, mem_f(14'd0));
        chk("d5_mem_en_count", 64'(men_cnt), 64'd2);
`endif
        wait_idle();

        // Randomized bursts with random back-pressure and AR issue times.
        fork
            begin
                for (int b = 0; b < 40; b++) begin
                    logic [31:0] a;
                    case ($urandom % 4)
                        0: a = $urandom % 32'h0001_0000;
                        1: a = 32'hFFFF_FFC0 + ($urandom % 32'h40);
                        2: a = $urandom;
                        default: a = 32'h0000_FFC0 + ($urandom % 32'h80);
                    endcase
                    repeat ($urandom % 6) step();
                    send_ar(4'($urandom), a, 4'($urandom));
                end
                wait_idle();
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    step();
                    RREADY_S = ($urandom % 4) != 0;
                end
            end
        join
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
